mealy_seq_detector_param: RTL and testbench

// - Generic serial bit-pattern detector built as a Mealy FSM. Pattern, length and overlap mode are set by parameters.
// - Successor to the fixed-pattern, fixed-mode detectors in this FSM library.
// - Takes a qualified 1-bit serial stream and pulses a registered match flag.
// - Optionally keeps a saturating match counter for status and debug.

---
 rtl/mealy_seq_detector_param.sv | 118 +++++++++++
 tb/tb_mealy_seq_detector_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mealy_seq_detector_param.sv
// mealy_seq_detector_param: generic serial pattern detector, Mealy FSM with registered match.
// Define SEQDET_MATCH_CNT_EN to add the saturating match_count output.
module mealy_seq_detector_param #(
  parameter int          PAT_LEN = 5,
  parameter logic [15:0] PATTERN = 16'h001B,
  parameter bit          OVERLAP = 1'b1,
  parameter int          CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_bit,
  input  logic                       clear,
  output logic                       match,
  output logic [$clog2(PAT_LEN)-1:0] state
`ifdef SEQDET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]           match_count
`endif
);

  localparam int SW = $clog2(PAT_LEN);

  localparam logic [31:0] MASK = (32'd1 << PAT_LEN) - 32'd1;
  localparam logic [31:0] PAT  = {16'd0, PATTERN} & MASK;

  if (PAT_LEN < 2 || PAT_LEN > 16 || CNT_W < 1) begin : g_bad_cfg
    $error("mealy_seq_detector_param: PAT_LEN must be 2..16, CNT_W >= 1");
  end

  // Longest proper suffix of the pattern that is also a prefix.
  function automatic int longest_border();
    int b;
    b = 0;
    for (int j = 1; j < PAT_LEN; j++) begin
      if ((PAT & ((32'd1 << j) - 32'd1)) == (PAT >> (PAT_LEN - j)))
        b = j;
    end
    return b;
  endfunction

  localparam int BORDER = longest_border();

  localparam logic [SW-1:0] NXT_HIT =
    OVERLAP ? SW'(BORDER) : '0;

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic          match_d;
  logic [31:0]   cand;
  int            k_len;
  int            fb_len;
  logic          hit;
  logic          hit_ok;
  logic          adv;

  // Candidate = matched prefix followed by the new bit, newest bit at LSB.
  always_comb begin
    k_len  = int'(state_q) + 1;
    cand   = ((PAT >> (PAT_LEN - int'(state_q))) << 1)
           | {31'd0, in_bit};
    fb_len = 0;
    for (int j = 1; j < PAT_LEN; j++) begin
      if (j <= k_len &&
          (cand & ((32'd1 << j) - 32'd1))
            == (PAT >> (PAT_LEN - j)))
        fb_len = j;
    end
    hit    = in_valid && (k_len == PAT_LEN) && (cand == PAT);
    hit_ok = hit && !clear;
    adv    = in_valid && !hit && !clear;
  end

  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    unique case (1'b1)
      clear:    state_d = '0;
      hit_ok: begin
        state_d = NXT_HIT;
        match_d = 1'b1;
      end
      adv:      state_d = SW'(fb_len);
      default:  state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      match   <= 1'b0;
    end else begin
      state_q <= state_d;
      match   <= match_d;
    end
  end

  assign state = state_q;

`ifdef SEQDET_MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (hit_ok && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_count = cnt_q;
`endif

endmodule

// File: tb/tb_mealy_seq_detector_param.sv
// tb_mealy_seq_detector_param: three detector configs driven in parallel,
// checked against a bit-history reference model.
module tb_mealy_seq_detector_param;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_bit;
  logic clear;

  logic       a_match, b_match, c_match;
  logic [2:0] a_state, b_state;
  logic [1:0] c_state;
`ifdef SEQDET_MATCH_CNT_EN
  logic [7:0] a_cnt, b_cnt;
  logic [1:0] c_cnt;
`endif

  always #5 clk = ~clk;

  mealy_seq_detector_param #(
    .PAT_LEN(5), .PATTERN(16'h001B), .OVERLAP(1'b1), .CNT_W(8)
  ) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .clear(clear), .match(a_match), .state(a_state)
`ifdef SEQDET_MATCH_CNT_EN
    , .match_count(a_cnt)
`endif
  );

  mealy_seq_detector_param #(
    .PAT_LEN(5), .PATTERN(16'h001B), .OVERLAP(1'b0), .CNT_W(8)
  ) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .clear(clear), .match(b_match), .state(b_state)
`ifdef SEQDET_MATCH_CNT_EN
    , .match_count(b_cnt)
`endif
  );

  mealy_seq_detector_param #(
    .PAT_LEN(4), .PATTERN(16'h000F), .OVERLAP(1'b1), .CNT_W(2)
  ) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .clear(clear), .match(c_match), .state(c_state)
`ifdef SEQDET_MATCH_CNT_EN
    , .match_count(c_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: raw history of accepted bits since the last restart.
  int          L[3]    = '{5, 5, 4};
  logic [15:0] P[3]    = '{16'h001B, 16'h001B, 16'h000F};
  bit          OV[3]   = '{1'b1, 1'b0, 1'b1};
  int          CMAX[3] = '{255, 255, 3};
  bit [63:0]   hist[3];
  int          hn[3];
  bit          e_match[3];
  int          e_state[3];
  int          e_cnt[3];

  function automatic bit tail_is_prefix(int m, int j);
    if (hn[m] < j) return 1'b0;
    for (int i = 0; i < j; i++) begin
      if (hist[m][j-1-i] != P[m][L[m]-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_rst();
    for (int m = 0; m < 3; m++) begin
      hn[m] = 0; e_match[m] = 1'b0; e_state[m] = 0; e_cnt[m] = 0;
    end
  endtask

  task automatic model_clk(bit v, bit b, bit c);
    for (int m = 0; m < 3; m++) begin
      if (c) begin
        hn[m] = 0; e_match[m] = 1'b0; e_state[m] = 0; e_cnt[m] = 0;
      end else if (!v) begin
        e_match[m] = 1'b0;
      end else begin
        hist[m] = {hist[m][62:0], b};
        if (hn[m] < 64) hn[m]++;
        e_match[m] = tail_is_prefix(m, L[m]);
        if (e_match[m]) begin
          if (e_cnt[m] < CMAX[m]) e_cnt[m]++;
          if (!OV[m]) hn[m] = 0;
        end
        e_state[m] = 0;
        for (int j = 1; j < L[m]; j++)
          if (tail_is_prefix(m, j)) e_state[m] = j;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string ctx);
    chk({ctx, "/a.match"}, 32'(a_match), 32'(e_match[0]));
    chk({ctx, "/a.state"}, 32'(a_state), 32'(e_state[0]));
    chk({ctx, "/b.match"}, 32'(b_match), 32'(e_match[1]));
    chk({ctx, "/b.state"}, 32'(b_state), 32'(e_state[1]));
    chk({ctx, "/c.match"}, 32'(c_match), 32'(e_match[2]));
    chk({ctx, "/c.state"}, 32'(c_state), 32'(e_state[2]));
`ifdef SEQDET_MATCH_CNT_EN
    chk({ctx, "/a.cnt"}, 32'(a_cnt), 32'(e_cnt[0]));
    chk({ctx, "/b.cnt"}, 32'(b_cnt), 32'(e_cnt[1]));
    chk({ctx, "/c.cnt"}, 32'(c_cnt), 32'(e_cnt[2]));
`endif
  endtask

  task automatic step(bit v, bit b, bit c, string ctx);
    in_valid = v; in_bit = b; clear = c;
    @(posedge clk);
    model_clk(v, b, c);
    #1;
    check_all(ctx);
    in_valid = 1'b0; clear = 1'b0;
  endtask

  initial begin
    bit s1[8];
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear = 1'b0;
    model_rst();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Test 1/2: 1,1,0,1,1,0,1,1 on overlap (a) and non-overlap (b)
    s1 = '{1, 1, 0, 1, 1, 0, 1, 1};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, s1[i], 1'b0, "t1");
      if (i == 4) begin
        chk("t1.hit5.a.match", 32'(a_match), 32'd1);
        chk("t1.hit5.a.state", 32'(a_state), 32'd2);
        chk("t1.hit5.b.match", 32'(b_match), 32'd1);
      end
    end
    chk("t1.hit8.a.match", 32'(a_match), 32'd1);
    chk("t2.bit8.b.match", 32'(b_match), 32'd0);
    chk("t2.bit8.b.state", 32'(b_state), 32'd2);

    // Test 3: gap transparency
    step(1'b0, 1'b0, 1'b1, "t3.clr");
    step(1'b1, 1'b1, 1'b0, "t3");
    step(1'b1, 1'b1, 1'b0, "t3");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, "t3.gap");
      chk("t3.gap.a.state", 32'(a_state), 32'd2);
    end
    step(1'b1, 1'b0, 1'b0, "t3");
    step(1'b1, 1'b1, 1'b0, "t3");
    step(1'b1, 1'b1, 1'b0, "t3");
    chk("t3.end.a.match", 32'(a_match), 32'd1);

    // Test 4: all-ones, back-to-back hits and counter saturation
    step(1'b0, 1'b0, 1'b1, "t4.clr");
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, 1'b0, "t4");
      if (i >= 4) chk("t4.c.match", 32'(c_match), 32'd1);
`ifdef SEQDET_MATCH_CNT_EN
      if (i >= 6) chk("t4.c.cnt_sat", 32'(c_cnt), 32'd3);
`endif
    end

    // Test 5: clear drops a hit in the same cycle
    step(1'b0, 1'b0, 1'b1, "t5.clr");
    step(1'b1, 1'b1, 1'b0, "t5");
    step(1'b1, 1'b1, 1'b0, "t5");
    step(1'b1, 1'b0, 1'b0, "t5");
    step(1'b1, 1'b1, 1'b0, "t5");
    step(1'b1, 1'b1, 1'b1, "t5.hitclr");
    chk("t5.a.match", 32'(a_match), 32'd0);
    chk("t5.a.state", 32'(a_state), 32'd0);
`ifdef SEQDET_MATCH_CNT_EN
    chk("t5.a.cnt", 32'(a_cnt), 32'd0);
`endif

    // Test 6: asynchronous reset mid-pattern
    step(1'b1, 1'b1, 1'b0, "t6");
    step(1'b1, 1'b1, 1'b0, "t6");
    step(1'b1, 1'b0, 1'b0, "t6");
    chk("t6.pre.a.state", 32'(a_state), 32'd3);
    rst = 1'b1;
    #2;
    model_rst();
    chk("t6.async.a.state", 32'(a_state), 32'd0);
    chk("t6.async.a.match", 32'(a_match), 32'd0);
    @(posedge clk);
    #1;
    check_all("t6.held");
    rst = 1'b0;
    s1 = '{1, 1, 0, 1, 1, 0, 0, 0};
    for (int i = 0; i < 5; i++) step(1'b1, s1[i], 1'b0, "t6.post");
    chk("t6.post.a.match", 32'(a_match), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 4) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 40) == 0,
           "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
